window3x3_gen: RTL and testbench

- Streaming 3x3 sliding-window generator. It is the producer side of the 3x3 convolution window interface.
- Accepts a raster-order pixel stream, one pixel per valid cycle. Emits a 9-element window per output cycle, ready to drive a 3x3 conv stage's data_i[9] directly.
- Uses two line buffers plus a 3x3 shift register.
- Valid-mode output only (no padding): output image is (IMG_WIDTH-2) x (IMG_HEIGHT-2).

---
 rtl/window3x3_gen.sv | 134 +++++++++++++
 tb/tb_window3x3_gen.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/window3x3_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : window3x3_gen
// Brief    : Streaming 3x3 sliding-window generator (valid mode, no padding).
//            Two line buffers hold rows r-1 and r-2; a 3x3 shift register
//            assembles the window whose bottom-right is the current pixel.
//            Optional macro WINDOW3X3_FRAME_FLAGS_EN adds sof_o / eol_o.
// Revision : 1.0 - initial release
// ============================================================================
module window3x3_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 128,
    parameter int IMG_HEIGHT = 96,
    parameter int CNT_WIDTH  = $clog2(IMG_WIDTH > IMG_HEIGHT ? IMG_WIDTH : IMG_HEIGHT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    input  logic                         sof_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    output logic                         valid_o,
    output logic signed [DATA_WIDTH-1:0] data_o [9]
`ifdef WINDOW3X3_FRAME_FLAGS_EN
    ,
    output logic                         sof_o,
    output logic                         eol_o
`endif
);

    localparam int                 c_aw       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] c_last_col = CNT_WIDTH'(IMG_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] c_last_row = CNT_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] c_two      = CNT_WIDTH'(2);

    logic [CNT_WIDTH-1:0]         r_col;
    logic [CNT_WIDTH-1:0]         r_row;
    logic signed [DATA_WIDTH-1:0] r_lb0 [IMG_WIDTH];
    logic signed [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];
    logic signed [DATA_WIDTH-1:0] r_win [9];

    logic [CNT_WIDTH-1:0]         w_col;
    logic [CNT_WIDTH-1:0]         w_row;
    logic [c_aw-1:0]              w_addr;
    logic                         w_last_col;
    logic                         w_last_row;
    logic                         w_gate;
    logic signed [DATA_WIDTH-1:0] w_lb0_rd;
    logic signed [DATA_WIDTH-1:0] w_lb1_rd;
    logic signed [DATA_WIDTH-1:0] w_new_col [3];
    logic signed [DATA_WIDTH-1:0] w_win_nxt [9];

    // sof_i overrides the counters so the accepted pixel is taken as (0,0).
    assign w_col      = sof_i ? '0 : r_col;
    assign w_row      = sof_i ? '0 : r_row;
    assign w_addr     = w_col[c_aw-1:0];
    assign w_last_col = (w_col == c_last_col);
    assign w_last_row = (w_row == c_last_row);
    assign w_gate     = valid_i && (w_row >= c_two) && (w_col >= c_two);

    // Reads happen before this cycle's write lands, giving rows r-2 / r-1.
    assign w_lb1_rd     = r_lb1[w_addr];
    assign w_lb0_rd     = r_lb0[w_addr];
    assign w_new_col[0] = w_lb1_rd;
    assign w_new_col[1] = w_lb0_rd;
    assign w_new_col[2] = data_i;

    // Each window row shifts left; the new right column enters top to bottom.
    for (genvar r = 0; r < 3; r++) begin : g_row
        assign w_win_nxt[3*r]   = r_win[3*r+1];
        assign w_win_nxt[3*r+1] = r_win[3*r+2];
        assign w_win_nxt[3*r+2] = w_new_col[r];
    end

    // Raster position of the next pixel, wrapping at line and frame ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (valid_i) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : w_row + CNT_WIDTH'(1);
            end else begin
                r_col <= w_col + CNT_WIDTH'(1);
                r_row <= w_row;
            end
        end
    end

    // Line buffers cascade: LB0 takes the new pixel, LB1 takes LB0's old value.
    always_ff @(posedge clk) begin
        if (valid_i) begin
            r_lb1[w_addr] <= w_lb0_rd;
            r_lb0[w_addr] <= data_i;
        end
    end

    // Window shift register advances on every accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) r_win[i] <= '0;
        end else if (valid_i) begin
            r_win <= w_win_nxt;
        end
    end

    // Output register loads only for windows inside the valid region, so it
    // holds its last value while valid_o is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= 1'b0;
            for (int i = 0; i < 9; i++) data_o[i] <= '0;
        end else begin
            valid_o <= w_gate;
            if (w_gate) data_o <= w_win_nxt;
        end
    end

`ifdef WINDOW3X3_FRAME_FLAGS_EN
    // Frame flags travel alongside the window they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sof_o <= 1'b0;
            eol_o <= 1'b0;
        end else begin
            sof_o <= w_gate && (w_row == c_two) && (w_col == c_two);
            eol_o <= w_gate && w_last_col;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_window3x3_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_window3x3_gen
// Brief    : Scoreboard bench for window3x3_gen; a 4x3 instance for the
//            functional cases and a 128x96 instance for the signed full frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_window3x3_gen;

    localparam int SW = 4;
    localparam int SH = 3;
    localparam int LW = 128;
    localparam int LH = 96;

    typedef struct {
        logic [71:0] win;
        logic        sof;
        logic        eol;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              s_valid, s_sof, s_vo;
    logic signed [7:0] s_data;
    logic signed [7:0] s_do [9];
    logic              l_valid, l_sof, l_vo;
    logic signed [7:0] l_data;
    logic signed [7:0] l_do [9];
`ifdef WINDOW3X3_FRAME_FLAGS_EN
    logic s_sofo, s_eolo, l_sofo, l_eolo;
`endif

    window3x3_gen #(.DATA_WIDTH(8), .IMG_WIDTH(SW), .IMG_HEIGHT(SH)) dut_s (
        .clk(clk), .rst(rst), .valid_i(s_valid), .sof_i(s_sof), .data_i(s_data),
        .valid_o(s_vo), .data_o(s_do)
`ifdef WINDOW3X3_FRAME_FLAGS_EN
        , .sof_o(s_sofo), .eol_o(s_eolo)
`endif
    );

    window3x3_gen #(.DATA_WIDTH(8), .IMG_WIDTH(LW), .IMG_HEIGHT(LH)) dut_l (
        .clk(clk), .rst(rst), .valid_i(l_valid), .sof_i(l_sof), .data_i(l_data),
        .valid_o(l_vo), .data_o(l_do)
`ifdef WINDOW3X3_FRAME_FLAGS_EN
        , .sof_o(l_sofo), .eol_o(l_eolo)
`endif
    );

    exp_t s_q[$];
    exp_t l_q[$];
    exp_t s_e, l_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   img [SH][SW];
    int   m_row, m_col;
    int   l_win_cnt = 0, l_sof_cnt = 0, l_eol_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [71:0] pack(input logic signed [7:0] w [9]);
        logic [71:0] p;
        for (int i = 0; i < 9; i++) p[71-8*i -: 8] = w[i];
        return p;
    endfunction

    // Small-instance output monitor: pops the scoreboard on each window.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_vo) begin
                if (s_q.size() == 0) begin
                    check("s_unexpected_window", 72'(s_q.size()), 72'd1);
                end else begin
                    s_e = s_q.pop_front();
                    check("s_latency", 72'(cyc), 72'(s_e.due));
                    check("s_window", pack(s_do), s_e.win);
`ifdef WINDOW3X3_FRAME_FLAGS_EN
                    check("s_sof_o", 72'(s_sofo), 72'(s_e.sof));
                    check("s_eol_o", 72'(s_eolo), 72'(s_e.eol));
`endif
                end
            end else if (s_q.size() > 0 && s_q[0].due <= cyc) begin
                s_e = s_q.pop_front();
                check("s_missing_window", 72'(s_vo), 72'd1);
            end
        end
    end

    // Large-instance output monitor, also tallying windows and flags.
    always @(negedge clk) begin
        if (!rst) begin
            if (l_vo) begin
                l_win_cnt++;
`ifdef WINDOW3X3_FRAME_FLAGS_EN
                if (l_sofo) l_sof_cnt++;
                if (l_eolo) l_eol_cnt++;
`endif
                if (l_q.size() == 0) begin
                    check("l_unexpected_window", 72'(l_q.size()), 72'd1);
                end else begin
                    l_e = l_q.pop_front();
                    check("l_latency", 72'(cyc), 72'(l_e.due));
                    check("l_window", pack(l_do), l_e.win);
`ifdef WINDOW3X3_FRAME_FLAGS_EN
                    check("l_sof_o", 72'(l_sofo), 72'(l_e.sof));
                    check("l_eol_o", 72'(l_eolo), 72'(l_e.eol));
`endif
                end
            end else if (l_q.size() > 0 && l_q[0].due <= cyc) begin
                l_e = l_q.pop_front();
                check("l_missing_window", 72'(l_vo), 72'd1);
            end
        end
    end

    task automatic idle_s(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_sof   = 1'b0;
        end
    endtask

    // Drive one pixel; the model keeps its own raster position and image copy.
    task automatic send_s(input int value, input logic sof);
        exp_t        e;
        logic [71:0] w;
        @(negedge clk);
        s_valid = 1'b1;
        s_sof   = sof;
        s_data  = 8'(value);
        if (sof) begin
            m_row = 0;
            m_col = 0;
        end
        img[m_row][m_col] = value;
        if (m_row >= 2 && m_col >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w[71-8*(3*i+j) -: 8] = 8'(img[m_row-2+i][m_col-2+j]);
            e.win = w;
            e.sof = (m_row == 2 && m_col == 2);
            e.eol = (m_col == SW - 1);
            e.due = cyc + 1;
            s_q.push_back(e);
        end
        if (m_col == SW - 1) begin
            m_col = 0;
            m_row = (m_row == SH - 1) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
    endtask

    task automatic send_frame_s(input int base, input logic sof_first, input logic gaps);
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++) begin
                send_s(base + r*16 + c, sof_first && r == 0 && c == 0);
                if (gaps) idle_s($urandom_range(0, 2));
            end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
        l_valid = 1'b0; l_sof = 1'b0; l_data = '0;
        m_row = 0; m_col = 0;
        #1;
        check("reset_valid_s", 72'(s_vo), 72'd0);
        check("reset_data_s", pack(s_do), 72'd0);
        check("reset_valid_l", 72'(l_vo), 72'd0);
        check("reset_data_l", pack(l_do), 72'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic 4x3 frame, back-to-back pixels.
        send_frame_s(0, 1'b1, 1'b0);
        idle_s(3);
        check("basic_w2_const", pack(s_do), 72'h01_02_03_11_12_13_21_22_23);

        // Same frame with random idle gaps.
        send_frame_s(0, 1'b1, 1'b1);
        idle_s(3);

        // Two frames back-to-back, second without sof_i.
        send_frame_s(0, 1'b1, 1'b0);
        send_frame_s(8'h40, 1'b0, 1'b0);
        idle_s(3);
        check("b2b_last_const", pack(s_do), 72'h41_42_43_51_52_53_61_62_63);

        // Restart with sof_i on the 6th pixel of a frame.
        for (int p = 0; p < 5; p++)
            send_s(8'h90 + (p / SW)*16 + (p % SW), p == 0);
        send_frame_s(8'hC0, 1'b1, 1'b0);
        idle_s(3);

        // Asynchronous reset mid-cycle while a window is being presented.
        for (int p = 0; p < 11; p++)
            send_s(8'h20 + (p / SW)*16 + (p % SW), p == 0);
        idle_s(1);
        #2;
        check("pre_reset_valid", 72'(s_vo), 72'd1);
        rst = 1'b1;
        #1;
        check("async_reset_valid", 72'(s_vo), 72'd0);
        check("async_reset_data", pack(s_do), 72'd0);
`ifdef WINDOW3X3_FRAME_FLAGS_EN
        check("async_reset_flags", {70'd0, s_sofo, s_eolo}, 72'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        m_row = 0;
        m_col = 0;
        // First pixel after reset is (0,0) without needing sof_i.
        send_frame_s(8'h30, 1'b0, 1'b0);
        idle_s(3);

        // Full-size signed frame of -128 on the large instance.
        for (int p = 0; p < LW*LH; p++) begin
            @(negedge clk);
            l_valid = 1'b1;
            l_sof   = (p == 0);
            l_data  = -8'sd128;
            if ((p / LW) >= 2 && (p % LW) >= 2) begin
                e.win = {9{8'h80}};
                e.sof = ((p / LW) == 2 && (p % LW) == 2);
                e.eol = ((p % LW) == LW - 1);
                e.due = cyc + 1;
                l_q.push_back(e);
            end
        end
        @(negedge clk);
        l_valid = 1'b0;
        l_sof   = 1'b0;
        idle_s(5);

        check("s_queue_drained", 72'(s_q.size()), 72'd0);
        check("l_queue_drained", 72'(l_q.size()), 72'd0);
        check("l_window_count", 72'(l_win_cnt), 72'((LW-2)*(LH-2)));
`ifdef WINDOW3X3_FRAME_FLAGS_EN
        check("l_sof_count", 72'(l_sof_cnt), 72'd1);
        check("l_eol_count", 72'(l_eol_cnt), 72'(LH-2));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
